// File: rtl/ddr2_reset_sequencer_if.sv
// Status/control bundle between system control logic and the DDR2 reset sequencer.
// master = system side (drives lock/ready/soft reset), slave = sequencer.
interface ddr2_reset_sequencer_if;
  logic       pll_locked;
  logic       phy_ready;
  logic       soft_reset_req;
  logic       ddr_usr_rst;
  logic       ready;
  logic       fail;
  logic [2:0] state;
  logic [7:0] retry_count;
  logic [7:0] drop_count;

  modport master (
    output pll_locked, phy_ready, soft_reset_req,
    input  ddr_usr_rst, ready, fail, state, retry_count, drop_count
  );

  modport slave (
    input  pll_locked, phy_ready, soft_reset_req,
    output ddr_usr_rst, ready, fail, state, retry_count, drop_count
  );
endinterface

// File: rtl/ddr2_reset_sequencer.sv
// Holds DDR2 infrastructure in reset, supervises PLL lock / PHY ready with bounded retries.
// Inputs reach the FSM after 2 sync flops + 1 edge; outputs registered; no backpressure.
module ddr2_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned READY_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input logic                   usr_clk,
  input logic                   usr_rst_n,
  ddr2_reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_ASSERT     = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_WAIT_READY = 3'd2,
    S_RUN        = 3'd3,
    S_FAIL       = 3'd4
  } state_e;

  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST  = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] READY_LAST = 32'(READY_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  retry_count_q, retry_count_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic        lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
  logic        ready_meta_q, ready_meta_d, ready_s_q, ready_s_d;
  logic        ddr_usr_rst_q, ddr_usr_rst_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        retry_evt;

  always_comb begin
    lock_meta_d   = bus.pll_locked;
    lock_s_d      = lock_meta_q;
    ready_meta_d  = bus.phy_ready;
    ready_s_d     = ready_meta_q;
    state_d       = state_q;
    retry_count_d = retry_count_q;
    drop_count_d  = drop_count_q;
    retry_evt     = 1'b0;

    case (state_q)
      S_ASSERT: begin
        if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q)                    state_d   = S_WAIT_READY;
        else if (timer_q == LOCK_LAST)   retry_evt = 1'b1;
      end
      S_WAIT_READY: begin
        // Losing lock while waiting for calibration is handled like a timeout.
        if (!lock_s_q)                   retry_evt = 1'b1;
        else if (ready_s_q)              state_d   = S_RUN;
        else if (timer_q == READY_LAST)  retry_evt = 1'b1;
      end
      S_RUN: begin
        if (!lock_s_q || !ready_s_q) begin
          state_d       = S_ASSERT;
          retry_count_d = 8'd0;
          if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_ASSERT;
    endcase

    if (retry_evt) begin
      if (retry_count_q == RETRY_MAX) begin
        state_d = S_FAIL;
      end else begin
        state_d       = S_ASSERT;
        retry_count_d = retry_count_q + 8'd1;
      end
    end

    // Soft reset overrides everything, but a drop counted this cycle is discarded.
    if (bus.soft_reset_req) begin
      state_d       = S_ASSERT;
      retry_count_d = 8'd0;
      drop_count_d  = drop_count_q;
    end

    timer_d       = ((state_d != state_q) || bus.soft_reset_req) ? 32'd0 : timer_q + 32'd1;
    ddr_usr_rst_d = (state_d == S_ASSERT) || (state_d == S_FAIL);
    ready_d       = (state_d == S_RUN);
    fail_d        = (state_d == S_FAIL);
  end

  always_ff @(posedge usr_clk) begin
    if (!usr_rst_n) begin
      state_q       <= S_ASSERT;
      timer_q       <= 32'd0;
      retry_count_q <= 8'd0;
      drop_count_q  <= 8'd0;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      ready_meta_q  <= 1'b0;
      ready_s_q     <= 1'b0;
      ddr_usr_rst_q <= 1'b1;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_count_q <= retry_count_d;
      drop_count_q  <= drop_count_d;
      lock_meta_q   <= lock_meta_d;
      lock_s_q      <= lock_s_d;
      ready_meta_q  <= ready_meta_d;
      ready_s_q     <= ready_s_d;
      ddr_usr_rst_q <= ddr_usr_rst_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.ddr_usr_rst = ddr_usr_rst_q;
  assign bus.ready       = ready_q;
  assign bus.fail        = fail_q;
  assign bus.retry_count = retry_count_q;
  assign bus.drop_count  = drop_count_q;

endmodule

// File: doc/ddr2_reset_sequencer.md
# ddr2_reset_sequencer

Drives the user reset request into the DDR2 clock/reset infrastructure and supervises bring-up from the user-clock side. It holds the memory subsystem in reset, waits for the PLL lock and PHY-ready indications, and reports readiness. On loss of lock or ready it re-issues the reset. Timeouts trigger bounded retries, then a sticky failure. It sits between system control logic (soft reset, status registers) and the DDR2 infrastructure's `usr_rst` input.

## Interface
- `RST_CYCLES`, 16: cycles `ddr_usr_rst` is held high per attempt (≥2)
- `LOCK_TIMEOUT`, 4096: max cycles spent in WAIT_LOCK (≥2)
- `READY_TIMEOUT`, 65536: max cycles spent in WAIT_READY (≥2)
- `MAX_RETRIES`, 3: retries after the initial attempt before FAIL (0–255)
- `usr_clk` in 1: sole clock
- `usr_rst_n` in 1: synchronous, active-low reset
- `pll_locked` in 1: PLL lock; asynchronous, double-flop synchronised internally
- `phy_ready` in 1: DDR-domain calibration done; asynchronous, double-flop synchronised
- `soft_reset_req` in 1: single-cycle request to restart the sequence
- `ddr_usr_rst` out 1: reset request to the infrastructure; active-high, registered
- `ready` out 1: memory usable; registered
- `fail` out 1: retries exhausted; sticky
- `state` out 3: ASSERT=0, WAIT_LOCK=1, WAIT_READY=2, RUN=3, FAIL=4
- `retry_count` out 8: retries used in the current sequence
- `drop_count` out 8: RUN→ASSERT drops since reset; saturates at 255

## Operation
- Synchronisers: 2 flops each, reset to 0. `lock_s` and `ready_s` are the second-stage outputs.
- Timer: 32-bit; cleared on every state change; increments each cycle otherwise.
- "Occupies N cycles" means the exit fires on the Nth edge in the state.
- ASSERT:
  - `ddr_usr_rst`=1.
  - Occupies exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s`=1, go to WAIT_READY.
  - Otherwise, on the LOCK_TIMEOUT-th cycle, take a timeout.
- WAIT_READY:
  - If `lock_s`=0, take a retry immediately, identical to a timeout.
  - Otherwise, if `ready_s`=1, go to RUN.
  - Otherwise, on the READY_TIMEOUT-th cycle, take a timeout.
- Timeout/retry:
  - If `retry_count`==MAX_RETRIES, go to FAIL.
  - Otherwise increment `retry_count` and go to ASSERT.
- RUN:
  - `ready`=1.
  - If `lock_s`=0 or `ready_s`=0, go to ASSERT, clear `retry_count`, and increment `drop_count` (saturating).
- FAIL:
  - `ddr_usr_rst`=1, `fail`=1, `ready`=0.
  - Exits only on `soft_reset_req` or reset.
- Priority per edge:
  1. `usr_rst_n`=0
  2. `soft_reset_req`: from any state go to ASSERT, clear `retry_count` and `fail`; `drop_count` unchanged.
  3. Normal transitions.
- A `soft_reset_req` arriving while already in ASSERT restarts the ASSERT period (timer cleared).
- `ddr_usr_rst`, `ready` and `fail` are decoded from the registered next state, so they change on the same edge as `state`.

## Timing
- Reset values while `usr_rst_n`=0:
  - state=ASSERT, `ddr_usr_rst`=1, `ready`=0, `fail`=0
  - `retry_count`=0, `drop_count`=0, timer=0, synchronisers=0
- Edge 1 is the first edge sampling `usr_rst_n`=1.
- `ddr_usr_rst` falls after edge RST_CYCLES.
- With both inputs high and stable from before reset release, `ready` rises after edge RST_CYCLES+2.
- Input-to-state latency: 2 cycles of synchroniser delay plus 1 edge. A `pll_locked` drop in RUN reaches `ddr_usr_rst`=1 three edges after the drop is sampled.
- Input pulses shorter than 1 cycle may be missed; this is acceptable.
- With `pll_locked` stuck low, FAIL is entered after (MAX_RETRIES+1)×(RST_CYCLES+LOCK_TIMEOUT) cycles.
- Reset mid-sequence returns to the reset values within one edge, regardless of state.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=8, READY_TIMEOUT=16, MAX_RETRIES=2.
- **Clean bring-up.** Both inputs held at 1; release reset → `ddr_usr_rst` falls after edge 4, `ready`=1 after edge 6, `retry_count`=0.
- **Lock stuck low.** `pll_locked`=0 forever → `ddr_usr_rst` pulses high 4 cycles, low 8 cycles, three times. FAIL with `fail`=1 and `retry_count`=2 after edge 36; `ddr_usr_rst` stays 1.
- **Late PHY ready.** `phy_ready` rises 20 cycles after `ddr_usr_rst` falls → first WAIT_READY times out after 16 cycles, `retry_count`=1. Second attempt reaches RUN.
- **Drop in RUN.** In RUN, drop `pll_locked` for 1 cycle → state=ASSERT 3 edges later, `drop_count`=1, `retry_count`=0. Re-reaches RUN with `ready`=1.
- **Soft reset.** In FAIL, pulse `soft_reset_req` → next edge state=ASSERT, `fail`=0, `retry_count`=0. With good inputs, `ready` rises 6 edges later.
- **Reset mid-sequence and priority.** Assert `usr_rst_n`=0 during WAIT_READY with timer=10 → all outputs return to reset values on that edge. `soft_reset_req` and a timeout in the same cycle → ASSERT with `retry_count`=0.
